// File: rtl/mem_access_ctrl.sv
// Memory access controller sitting between the CPU's MAR/MDR side and a
// single-clock 512x32 RAM with registered read data. It runs one read or
// write at a time, hides the RAM's one-cycle read latency and never raises
// we while a read is in flight.
module mem_access_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD1  = 3'd2,
    S_RD2  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_accept;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_wr;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_ready;
  logic                  r_done;
  logic                  r_we;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; a request is only taken in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_accept    = 1'b1;
          w_state_nxt = wr ? S_WR : S_RD1;
        end
      end
      S_WR:    w_state_nxt = S_DONE;
      S_RD1:   w_state_nxt = S_RD2;
      S_RD2:   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake and RAM strobe, registered from the upcoming state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
      r_we    <= (w_state_nxt == S_WR);
    end
  end

  // Request capture; held until the controller is back in IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= addr;
      r_wdata <= wdata;
      r_wr    <= wr;
    end
  end

  // MDR: loaded only when registered RAM data is valid on a read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else if ((r_state == S_RD2) && !r_wr) begin
      r_rdata <= ram_q;
    end
  end

  assign ready          = r_ready;
  assign done           = r_done;
  assign ram_we         = r_we;
  assign rdata          = r_rdata;
  assign ram_data       = r_wdata;
  assign ram_read_addr  = r_addr;
  assign ram_write_addr = r_addr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a 512x32 registered-output RAM, a
// transaction-level schedule model of the controller and directed stimulus.
module tb_mem_access_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 9;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ready;
  logic          done;
  logic [DW-1:0] rdata;
  logic [DW-1:0] ram_data;
  logic [AW-1:0] ram_read_addr;
  logic [AW-1:0] ram_write_addr;
  logic          ram_we;
  logic [DW-1:0] ram_q;

  always #5 clk = ~clk;

  mem_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .wr            (wr),
    .addr          (addr),
    .wdata         (wdata),
    .ready         (ready),
    .done          (done),
    .rdata         (rdata),
    .ram_data      (ram_data),
    .ram_read_addr (ram_read_addr),
    .ram_write_addr(ram_write_addr),
    .ram_we        (ram_we),
    .ram_q         (ram_q)
  );

  // RAM: write when we, otherwise register the read; no read in a write cycle
  logic [DW-1:0] ram_mem [0:511];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_write_addr] <= ram_data;
    else        ram_q <= ram_mem[ram_read_addr];
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted request schedules when we, done, ready and rdata
  // must show up, counted in clock edges since reset release.
  int            m_cyc      = 0;
  int            m_ready_at = 0;
  int            m_we_at    = -1;
  int            m_done_at  = -1;
  int            m_rd_at    = -1;
  logic [DW-1:0] m_rd_val   = '0;
  logic [DW-1:0] m_rdata    = '0;
  logic [AW-1:0] m_addr     = '0;
  logic [DW-1:0] m_wdata    = '0;
  logic          m_pend     = 1'b0;
  int            m_pend_at  = -1;
  logic [DW-1:0] m_mem [0:511];

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_cyc = 0; m_ready_at = 0; m_we_at = -1; m_done_at = -1; m_rd_at = -1;
        m_rdata = '0; m_addr = '0; m_wdata = '0; m_pend = 1'b0; m_pend_at = -1;
      end else begin
        m_cyc++;
        if (m_pend && m_cyc == m_pend_at) begin
          m_mem[m_addr] = m_wdata;
          m_pend = 1'b0;
        end
        if (m_cyc == m_rd_at) m_rdata = m_rd_val;
        if ((m_cyc - 1) >= m_ready_at && req === 1'b1) begin
          m_addr  = addr;
          m_wdata = wdata;
          if (wr) begin
            m_we_at = m_cyc; m_done_at = m_cyc + 1; m_ready_at = m_cyc + 2;
            m_pend = 1'b1; m_pend_at = m_cyc + 1;
          end else begin
            m_rd_val = m_mem[addr];
            m_rd_at = m_cyc + 2; m_done_at = m_cyc + 2; m_ready_at = m_cyc + 3;
          end
        end
      end
    end
  end

  function automatic logic exp_ready();
    return m_cyc >= m_ready_at;
  endfunction

  // Compare process: every cycle, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      check("ready",      32'(ready),          32'(exp_ready()));
      check("done",       32'(done),           32'(m_cyc == m_done_at));
      check("ram_we",     32'(ram_we),         32'(m_cyc == m_we_at));
      check("rdata",      rdata,               m_rdata);
      check("ram_rd_adr", 32'(ram_read_addr),  32'(m_addr));
      check("ram_wr_adr", 32'(ram_write_addr), 32'(m_addr));
      check("ram_data",   ram_data,            m_wdata);
    end
  end

  int done_pulses = 0;
  int we_cycles   = 0;
  initial forever begin @(negedge clk); if (done === 1'b1) done_pulses++; end
  initial forever begin @(posedge clk); if (ram_we === 1'b1) we_cycles++; end

  // Drive one request once the model says the controller is idle; returns
  // the accept edge number. Called and returns on a falling edge.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int acc);
    int n = 0;
    while (!exp_ready() && n < 20) begin @(negedge clk); n++; end
    check("issue_wait", 32'(exp_ready()), 32'd1);
    wr = w; addr = a; wdata = d; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    acc = m_cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!exp_ready() && n < 20) begin @(negedge clk); n++; end
    check("idle_wait", 32'(exp_ready()), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int a0, a1, a2, w0, d0;
    reset_n = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done",  32'(done),  32'd0);
    check("rst_we",    32'(ram_we), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Preload through the controller
    issue(1'b1, 9'h000, 32'hA5A5A5A5, a0);
    issue(1'b1, 9'h0AA, 32'h00000001, a0);
    issue(1'b1, 9'h020, 32'h0BADF00D, a0);
    issue(1'b1, 9'h010, 32'h13572468, a0);
    wait_idle();

    // Write then read back
    w0 = we_cycles; d0 = done_pulses;
    issue(1'b1, 9'h005, 32'hDEADBEEF, a0);
    wait_idle();
    check("wr_we_once",   32'(we_cycles - w0),   32'd1);
    check("wr_done_once", 32'(done_pulses - d0), 32'd1);
    issue(1'b0, 9'h005, 32'h0, a0);
    wait_idle();
    check("rd_005", rdata, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    check("rd_005_hold", rdata, 32'hDEADBEEF);

    // Requests while busy are dropped
    w0 = we_cycles; d0 = done_pulses;
    issue(1'b0, 9'h010, 32'h0, a0);
    req = 1'b1; wr = 1'b1; addr = 9'h011; wdata = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    req = 1'b0; wr = 1'b0;
    wait_idle();
    check("busy_no_we",   32'(we_cycles - w0),   32'd0);
    check("busy_done_1",  32'(done_pulses - d0), 32'd1);
    check("busy_rd_010",  rdata, 32'h13572468);

    // Back-to-back at the address boundaries
    issue(1'b1, 9'h1FF, 32'h12345678, a0);
    issue(1'b0, 9'h1FF, 32'h0, a1);
    repeat (2) @(negedge clk);
    check("b2b_rd_1ff", rdata, 32'h12345678);
    issue(1'b0, 9'h000, 32'h0, a2);
    wait_idle();
    check("b2b_rd_000", rdata, 32'hA5A5A5A5);
    check("b2b_gap_wr", 32'(a1 - a0), 32'd3);
    check("b2b_gap_rd", 32'(a2 - a1), 32'd4);

    // Reset while the write is in its WR cycle
    d0 = done_pulses;
    issue(1'b1, 9'h0AA, 32'hFFFFFFFF, a0);
    #1 reset_n = 1'b0;
    #1;
    check("abort_we",    32'(ram_we), 32'd0);
    check("abort_ready", 32'(ready),  32'd1);
    check("abort_done",  32'(done),   32'd0);
    check("abort_rdata", rdata, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("abort_no_done", 32'(done_pulses - d0), 32'd0);
    check("abort_mem",     ram_mem[9'h0AA], 32'h00000001);
    issue(1'b0, 9'h0AA, 32'h0, a0);
    wait_idle();
    check("abort_rd_0aa", rdata, 32'h00000001);

    // Inputs wander during a read
    issue(1'b0, 9'h020, 32'h0, a0);
    for (int i = 0; i < 4; i++) begin
      addr = addr ^ 9'h1FF; wr = ~wr;
      check("unstable_adr", 32'(ram_read_addr), 32'h020);
      @(negedge clk);
    end
    wr = 1'b0;
    wait_idle();
    check("unstable_rd", rdata, 32'h0BADF00D);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end

endmodule
